// File: rtl/regfile_2w2r_clr.sv
// Two-write / two-read register file with a sequential hardware clear.
// Entries are zeroed one per cycle while busy; reads return zero until the sweep completes.
module regfile_2w2r_clr #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy
);

  typedef enum logic {StClear, StReady} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  logic wr0_ok, wr1_ok;
  assign wr0_ok = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1_ok = we1 && !(ZERO_REG != 0 && wa1 == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = StReady;
          busy_d  = 1'b0;
        end
      end
      StReady: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == StClear) begin
      mem_d[cnt_q] = '0;
    end else begin
      if (wr0_ok) mem_d[wa0] = wd0;
      if (wr1_ok) mem_d[wa1] = wd1;
    end
  end

  // The array itself has no reset; holding it during reset keeps writes from landing.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q <= mem_d;
    end
  end

  function automatic logic [XLEN-1:0] rd_sel(input logic [AW-1:0] ra);
    logic [XLEN-1:0] v;
    v = mem_q[ra];
    if (BYPASS != 0) begin
      if (we0 && wa0 == ra) v = wd0;
      if (we1 && wa1 == ra) v = wd1;
    end
    if (state_q != StReady || (ZERO_REG != 0 && ra == '0)) v = '0;
    return v;
  endfunction

  assign rd1  = rd_sel(ra1);
  assign rd2  = rd_sel(ra2);
  assign busy = busy_q;

endmodule

// File: tb/tb_regfile_2w2r_clr.sv
// Bench for regfile_2w2r_clr: a default instance and a small no-bypass instance share stimulus.
// A per-instance reference model is compared against both every cycle.
module tb_regfile_2w2r_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr_req = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;

  logic [31:0] a_rd1, a_rd2;
  logic        a_busy;
  logic [15:0] b_rd1, b_rd2;
  logic        b_busy;

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  regfile_2w2r_clr dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2), .busy(a_busy)
  );

  regfile_2w2r_clr #(.XLEN(16), .NREG(8), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .we0(we0), .wa0(wa0[2:0]), .wd0(wd0[15:0]),
    .we1(we1), .wa1(wa1[2:0]), .wd1(wd1[15:0]),
    .ra1(ra1[2:0]), .ra2(ra2[2:0]), .rd1(b_rd1), .rd2(b_rd2), .busy(b_busy)
  );

  // Reference model: instance 0 = default config, instance 1 = NREG 8 / XLEN 16 / no bypass.
  int          nreg_c[2] = '{32, 8};
  logic [31:0] dmask[2]  = '{32'hFFFF_FFFF, 32'h0000_FFFF};
  bit          byp[2]    = '{1'b1, 1'b0};
  bit          clearing[2] = '{1'b1, 1'b1};
  int          left[2]     = '{32, 8};
  logic [31:0] mmem[2][64];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      int a0, a1;
      a0 = int'(wa0) % nreg_c[i];
      a1 = int'(wa1) % nreg_c[i];
      if (!rst_n) begin
        clearing[i] = 1'b1;
        left[i]     = nreg_c[i];
      end else if (clearing[i]) begin
        mmem[i][nreg_c[i] - left[i]] = '0;
        left[i] = left[i] - 1;
        if (left[i] == 0) clearing[i] = 1'b0;
      end else begin
        if (we0 && a0 != 0) mmem[i][a0] = wd0 & dmask[i];
        if (we1 && a1 != 0) mmem[i][a1] = wd1 & dmask[i];
        if (clr_req) begin
          clearing[i] = 1'b1;
          left[i]     = nreg_c[i];
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int i, input logic [4:0] ra);
    int a;
    a = int'(ra) % nreg_c[i];
    if (clearing[i] || a == 0) return '0;
    if (byp[i] && we1 && int'(wa1) % nreg_c[i] == a) return wd1 & dmask[i];
    if (byp[i] && we0 && int'(wa0) % nreg_c[i] == a) return wd0 & dmask[i];
    return mmem[i][a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("a_rd1", a_rd1, exp_rd(0, ra1));
      chk("a_rd2", a_rd2, exp_rd(0, ra2));
      chk("a_busy", {31'b0, a_busy}, {31'b0, clearing[0]});
      chk("b_rd1", {16'b0, b_rd1}, exp_rd(1, ra1));
      chk("b_rd2", {16'b0, b_rd2}, exp_rd(1, ra2));
      chk("b_busy", {31'b0, b_busy}, {31'b0, clearing[1]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
  endtask

  task automatic measure(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int n = 1; n <= 100 && (na < 0 || nb < 0); n++) begin
      cyc();
      if (na < 0 && !a_busy) na = n;
      if (nb < 0 && !b_busy) nb = n;
    end
  endtask

  initial begin
    int na, nb;
    #1 rst_n = 1'b0;
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1234_5678; ra1 = 5'd5;
    repeat (3) cyc();
    chk("rst_busy_a", {31'b0, a_busy}, 32'd1);
    chk("rst_rd1_a", a_rd1, 32'd0);
    idle();
    rst_n = 1'b1;
    measure(na, nb);
    chk("init_clear_len_a", na, 32'd32);
    chk("init_clear_len_b", nb, 32'd8);

    // Same-cycle forwarding versus stored read.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra1 = 5'd5;
    #1;
    chk("byp_a", a_rd1, 32'hDEAD_BEEF);
    chk("nobyp_b", {16'b0, b_rd1}, 32'd0);
    cyc(); idle(); #1;
    chk("stored_a", a_rd1, 32'hDEAD_BEEF);
    chk("stored_b", {16'b0, b_rd1}, 32'h0000_BEEF);

    // Collision: port 1 wins.
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22; ra1 = 5'd7;
    #1;
    chk("coll_byp_a", a_rd1, 32'h22);
    cyc(); idle(); ra2 = 5'd7; #1;
    chk("coll_a", a_rd1, 32'h22);
    chk("coll_b", {16'b0, b_rd2}, 32'h22);

    // Writes to entry 0 are discarded, bypass included.
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; ra2 = 5'd0;
    #1;
    chk("zero_byp_a", a_rd2, 32'd0);
    cyc(); idle(); #1;
    chk("zero_a", a_rd2, 32'd0);

    // Two distinct writes in one cycle.
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd9; wa1 = 5'd10; wd0 = 32'h0909_0909; wd1 = 32'h0A0A_0A0A;
    ra1 = 5'd9; ra2 = 5'd10;
    cyc(); idle();

    // Fill 1..31 through port 0.
    for (int i = 1; i < 32; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = {8'hA5, 24'(i)};
      ra1 = 5'(i - 1); ra2 = 5'(i);
      cyc();
    end
    idle(); ra1 = 5'd4; #1;
    chk("fill_a", a_rd1, 32'hA500_0004);
    chk("fill_b", {16'b0, b_rd1}, 32'h0000_001C);

    // Write and clear on the same edge, then writes and clr_req while clearing.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA; clr_req = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      we0 = 1'b1; wa0 = 5'(k + 1); wd0 = 32'hC0DE_0000 + k;
      we1 = 1'b1; wa1 = 5'(k + 9); wd1 = 32'hBEEF_0000 + k;
      clr_req = (k == 3); ra1 = 5'(k + 1); ra2 = 5'(k + 9);
      #1;
      chk("clr_rd1_a", a_rd1, 32'd0);
      cyc();
    end
    idle();
    measure(na, nb);
    chk("clr_len_a", na + 6, 32'd32);
    chk("clr_len_b", nb + 6, 32'd8);
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      chk("swept_a", a_rd1, 32'd0);
      cyc();
    end

    // Reset in the middle of a clear restarts it from entry 0.
    clr_req = 1'b1;
    cyc(); idle();
    repeat (10) cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    measure(na, nb);
    chk("rst_mid_len_a", na, 32'd32);
    chk("rst_mid_len_b", nb, 32'd8);

    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h0000_5A5A; ra1 = 5'd2;
    cyc(); idle(); #1;
    chk("post_a", a_rd1, 32'h0000_5A5A);
    cyc();

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
